nios_dbg_scan_bridge: RTL



---
 rtl/nios_dbg_pkg.sv | 30 +++
 rtl/nios_dbg_action_decode.sv | 42 ++++
 rtl/nios_dbg_scan_bridge.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/nios_dbg_pkg.sv
// -----------------------------------------------------------------------------
// nios_dbg_pkg
// Shared types and helpers for the debug scan bridge.
//   state_t     : scan FSM states (IDLE, SHIFT, UPDATE)
//   cnt_width() : shift-counter width for a given frame length, clog2(len+2),
//                 wide enough to count past the frame and saturate there
//   action_idx(): index of the action bit within a DR word (DR_W-1)
//   ACTION_BIT  : action-bit index for the default 38-bit data register
// Optional feature macro used by the bridge: NIOS_DBG_SCAN_PARITY_EN.
// -----------------------------------------------------------------------------
package nios_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int unsigned DFLT_DR_W  = 32'd38;
  localparam int unsigned ACTION_BIT = DFLT_DR_W - 32'd1;

  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len + 32'd2);
  endfunction

  function automatic int unsigned action_idx(input int unsigned dr_w);
    return dr_w - 32'd1;
  endfunction

endpackage

// File: rtl/nios_dbg_action_decode.sv
// -----------------------------------------------------------------------------
// nios_dbg_action_decode
// Registered one-hot decoder for the per-channel action pulses.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   fire            : an update was accepted this cycle
//   action          : action bit of the accepted word
//   ir_q            : latched instruction (channel index)
//   take_action     : NUM_CH-wide one-cycle pulse, action bit = 1
//   take_no_action  : NUM_CH-wide one-cycle pulse, action bit = 0
// At most one bit across both outputs is set in any cycle because fire is a
// single strobe and the channel compare matches exactly one index.
// -----------------------------------------------------------------------------
module nios_dbg_action_decode
  import nios_dbg_pkg::*;
#(
  parameter int IR_W   = 2,
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fire,
  input  logic              action,
  input  logic [IR_W-1:0]   ir_q,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action
);

  // Pulses are rebuilt every cycle, so they self-clear one cycle after fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        take_action[c]    <= fire &  action & (ir_q == IR_W'(c));
        take_no_action[c] <= fire & ~action & (ir_q == IR_W'(c));
      end
    end
  end

endmodule

// File: rtl/nios_dbg_scan_bridge.sv
// -----------------------------------------------------------------------------
// nios_dbg_scan_bridge
// Single-clock debug scan bridge: latches an instruction on update-IR, captures
// the selected channel word on capture-DR, shifts it LSB-first against tdi, and
// on a well-formed update-DR presents the shifted word on jdo together with a
// one-cycle take_action / take_no_action pulse for the selected channel.
// Strobe priority per cycle: reset > vs_uir > vs_cdr > vs_udr > vs_sdr.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   ir_in, vs_uir     : instruction value and update-IR strobe
//   vs_cdr            : capture-DR strobe
//   vs_sdr, tdi       : shift-DR strobe (one per bit) and serial data in
//   vs_udr            : update-DR strobe
//   capture_data      : per-channel capture words, channel c at [c*DR_W +: DR_W]
//   err_clr           : clears the sticky error flags (a simultaneous set wins)
//   tdo               : serial data out (sr[0])
//   jdo               : last accepted update word
//   take_action       : per-channel pulse, action bit = 1
//   take_no_action    : per-channel pulse, action bit = 0
//   ir_q              : latched instruction
//   len_err           : sticky, update arrived with a wrong shift count
//   parity_err        : sticky, frame parity was odd (parity build only)
//
// Optional feature macro: NIOS_DBG_SCAN_PARITY_EN
//   Frame becomes DR_W+1 bits; the top bit sr[DR_W] is an even-parity bit that
//   trails the data on tdo and is shifted in last on tdi. Captured words get
//   their own parity appended. Without the macro parity_err is tied to 0.
// -----------------------------------------------------------------------------
module nios_dbg_scan_bridge
  import nios_dbg_pkg::*;
#(
  parameter int IR_W   = 2,
  parameter int DR_W   = 38,
  parameter int NUM_CH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   vs_uir,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic                   tdi,
  input  logic [NUM_CH*DR_W-1:0] capture_data,
  input  logic                   err_clr,
  output logic                   tdo,
  output logic [DR_W-1:0]        jdo,
  output logic [NUM_CH-1:0]      take_action,
  output logic [NUM_CH-1:0]      take_no_action,
  output logic [IR_W-1:0]        ir_q,
  output logic                   len_err,
  output logic                   parity_err
);

`ifdef NIOS_DBG_SCAN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  localparam int FR_W  = DR_W + PB;
  localparam int CNT_W = cnt_width(FR_W);
  localparam int ACT   = action_idx(DR_W);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FR_W + 1);

  state_t            state;
  logic [FR_W-1:0]   sr;
  logic [CNT_W-1:0]  cnt;

  logic [DR_W-1:0]   cap_word;
  logic [FR_W-1:0]   cap_frame;
  logic              ch_ok;
  logic              len_ok;
  logic              par_ok;
  logic              accept;

  // Capture-source mux: instructions with no channel capture zero.
  always_comb begin
    cap_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ir_q == IR_W'(c)) begin
        cap_word = capture_data[c*DR_W +: DR_W];
      end else begin
        cap_word = cap_word;
      end
    end
  end

  // The instruction compare is done at 32 bits so NUM_CH == 2**IR_W works.
  assign ch_ok  = ({{(32-IR_W){1'b0}}, ir_q} < 32'(NUM_CH));
  assign len_ok = (cnt == CNT_FULL);

`ifdef NIOS_DBG_SCAN_PARITY_EN
  assign cap_frame = {^cap_word, cap_word};
  assign par_ok    = ~(^sr);
`else
  assign cap_frame  = cap_word;
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Update is accepted only when no higher-priority strobe shares the cycle.
  assign accept = vs_udr & ~vs_uir & ~vs_cdr & (state == SHIFT) &
                  ch_ok & len_ok & par_ok;

  assign tdo = sr[0];

  // Scan FSM, shift register, counter, instruction latch and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      ir_q    <= '0;
      jdo     <= '0;
      len_err <= 1'b0;
`ifdef NIOS_DBG_SCAN_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      // Clear first so that a set later in this block overrides it.
      if (err_clr) begin
        len_err <= 1'b0;
`ifdef NIOS_DBG_SCAN_PARITY_EN
        parity_err <= 1'b0;
`endif
      end

      if (vs_uir) begin
        // Aborts any shift in progress silently.
        ir_q  <= ir_in;
        state <= IDLE;
      end else if (vs_cdr) begin
        sr    <= cap_frame;
        cnt   <= '0;
        state <= SHIFT;
      end else if (vs_udr && (state == SHIFT)) begin
        state <= IDLE;
        if (!ch_ok) begin
          // Unmapped instruction: dropped without an error.
          state <= IDLE;
        end else if (!len_ok) begin
          len_err <= 1'b1;
`ifdef NIOS_DBG_SCAN_PARITY_EN
        end else if (!par_ok) begin
          parity_err <= 1'b1;
`endif
        end else begin
          jdo   <= sr[DR_W-1:0];
          state <= UPDATE;
        end
      end else if (vs_sdr && (state == SHIFT)) begin
        sr <= {tdi, sr[FR_W-1:1]};
        // Saturate one past the frame so over-long shifts never wrap to a
        // count that would be accepted.
        if (cnt != CNT_SAT) begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (state == UPDATE) begin
        state <= IDLE;
      end
    end
  end

  nios_dbg_action_decode #(
    .IR_W   (IR_W),
    .NUM_CH (NUM_CH)
  ) u_action_decode (
    .clk            (clk),
    .reset          (reset),
    .fire           (accept),
    .action         (sr[ACT]),
    .ir_q           (ir_q),
    .take_action    (take_action),
    .take_no_action (take_no_action)
  );

endmodule
